split_mux_rd_sched: RTL and testbench
=====================================

Name: split_mux_rd_sched

Overview:
- Read scheduler for the two-level one-hot split mux register read-back network.
- Arbitrates NREQ requesters round-robin and keeps one transaction in flight.
- Converts the granted index to a one-cycle one-hot select pulse and samples the mux output after the mux pipeline latency.
- Returns data or an error on a single shared response channel with valid/ready.

Parameters:
- WIDTH, 32: data width of the mux output.
- CNT, 31: number of mux inputs, which is the width of the one-hot select.
- AW, 5: request index width; must satisfy 2^AW >= CNT.
- NREQ, 2: number of requesters, at least 1.
- IDW, 1: rsp_id width; must satisfy 2^IDW >= NREQ.
- LATENCY, 2: cycles from the mux_sel pulse to valid mux_dout/mux_dout_vld, range 0..2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_vld  input  NREQ  per-requester read request.
- req_addr  input  NREQ*AW  per-requester input index; requester i uses slice [i*AW +: AW].
- req_rdy  output  NREQ  one-hot accept pulse.
- mux_sel  output  CNT  one-hot select to the split mux.
- mux_dout_vld  input  1  mux hit flag.
- mux_dout  input  WIDTH  mux data.
- rsp_vld  output  1  response valid.
- rsp_rdy  input  1  response accept.
- rsp_id  output  IDW  requester number of the response.
- rsp_data  output  WIDTH  read data.
- rsp_err  output  1  error: decode miss or index out of range.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, synchronous on rst=1:
  - Outputs: req_rdy=0, mux_sel=0, rsp_vld=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - State goes to IDLE.
  - RR pointer set to NREQ-1, so requester 0 wins first.
- Reset mid-transaction abandons it. A mux_dout_vld arriving later from the abandoned pulse is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_vld=1:
  - Grant the first requesting index after the RR pointer, wrapping at NREQ.
  - Pulse req_rdy[g] for exactly 1 cycle.
  - Capture g and its address. Update the RR pointer to g.
  - Go to ISSUE.
- IDLE with no request: stay in IDLE.
- ISSUE, address >= CNT:
  - mux_sel stays 0 (no pulse).
  - Load response with rsp_err=1, rsp_data=0. Go to RESP.
- ISSUE, address < CNT:
  - Drive mux_sel = 1<<addr for exactly this one cycle.
  - LATENCY=0: sample mux_dout/mux_dout_vld in this same cycle and go to RESP.
  - LATENCY>0: load the down-counter with LATENCY and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, sample mux_dout and mux_dout_vld.
  - rsp_data = mux_dout when mux_dout_vld=1, else 0.
  - rsp_err = ~mux_dout_vld.
  - Go to RESP.
- mux_dout_vld is ignored in every cycle except the sample cycle.
- RESP:
  - rsp_vld=1; rsp_id/rsp_data/rsp_err held stable until rsp_rdy=1.
  - On rsp_vld&rsp_rdy: rsp_vld drops next cycle and state returns to IDLE.
- Response timing:
  - rsp_vld is registered: first asserted 1 cycle after the sample cycle.
  - Minimum request-accept to rsp_vld: LATENCY+2 cycles.
  - Back-to-back throughput: one transaction per LATENCY+3 cycles with rsp_rdy tied high.
- req_rdy is 0 outside IDLE, so new requests wait; req_vld must stay high until accepted.
- Simultaneous requests in IDLE are resolved only by the RR pointer. No starvation: each waiting requester is served within NREQ grants.
- A requester may drop req_vld before it is granted with no side effects.

Optional Feature:
- Macro: SPLIT_MUX_RD_SCHED_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (16 bits) and input err_cnt_clr (1 bit).
  - err_cnt increments on each handshaked response with rsp_err=1 and saturates at 0xFFFF.
  - err_cnt_clr=1 zeroes it; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: the ports and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use defaults CNT=31, WIDTH=32, LATENCY=2, NREQ=2.
1. Single read: req0 addr=5, mux model returns 0xDEADBEEF with vld at +2 cycles → mux_sel=0x00000020 pulses for 1 cycle; rsp_vld 4 cycles after accept with rsp_id=0, rsp_data=0xDEADBEEF, rsp_err=0.
2. Decode miss: req1 addr=7, model holds mux_dout_vld=0 → rsp_id=1, rsp_err=1, rsp_data=0.
3. Out of range: req0 addr=31 → mux_sel stays 0 for the whole transaction; rsp_err=1, rsp_data=0.
4. Contention: req0 and req1 held high for 4 transactions, rsp_rdy=1 → grant order 0,1,0,1; req_rdy is never 2'b11.
5. Backpressure and reset: rsp_rdy=0 for 10 cycles → rsp_* stable and req_rdy=0 throughout. Assert rst in WAIT of the next transaction → next cycle all outputs 0, busy=0, and a stale mux_dout_vld 1 cycle later produces no response.
6. With SPLIT_MUX_RD_SCHED_ERR_CNT_EN defined: 3 error responses → err_cnt=3; err_cnt_clr together with a 4th error response → err_cnt=0.

Source files
------------

// File: rtl/split_mux_rd_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : split_mux_rd_sched_if
// Desc    : Request, mux and response signals of the split-mux read scheduler.
// Rev     : 1.0  initial release
// ============================================================================
interface split_mux_rd_sched_if #(
  parameter int WIDTH = 32,
  parameter int CNT   = 31,
  parameter int AW    = 5,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_rdy;
  logic [CNT-1:0]     mux_sel;
  logic               mux_dout_vld;
  logic [WIDTH-1:0]   mux_dout;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [IDW-1:0]     rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
  logic               busy;

  // master is the environment: requesters, the split mux and the response sink
  modport master (
    output req_vld, req_addr, mux_dout_vld, mux_dout, rsp_rdy,
    input  req_rdy, mux_sel, rsp_vld, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_vld, req_addr, mux_dout_vld, mux_dout, rsp_rdy,
    output req_rdy, mux_sel, rsp_vld, rsp_id, rsp_data, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/split_mux_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : split_mux_rd_sched
// Desc    : Round-robin read scheduler for the split one-hot mux read-back
//           network; one transaction in flight, valid/ready response channel.
// Option  : SPLIT_MUX_RD_SCHED_ERR_CNT_EN adds err_cnt / err_cnt_clr.
// Rev     : 1.0  initial release
// ============================================================================
module split_mux_rd_sched #(
  parameter int WIDTH   = 32,
  parameter int CNT     = 31,
  parameter int AW      = 5,
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int LATENCY = 2
) (
  input  wire logic clk,
  input  wire logic rst,
`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
  input  wire logic   err_cnt_clr,
  output logic [15:0] err_cnt,
`endif
  split_mux_rd_sched_if.slave bus
);

  localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] c_cnt_lim = (AW+1)'(CNT);
  localparam logic [1:0]  c_lat     = 2'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, r_gnt;
  logic [AW-1:0]    r_addr;
  logic [1:0]       r_cnt;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [AW-1:0]    w_addr_arr [NREQ];
  logic [PW-1:0]    w_cand, w_gnt_idx;
  logic             w_gnt_found, w_in_range;
  logic [NREQ-1:0]  w_req_rdy;
  logic [CNT-1:0]   w_mux_sel;
  logic             w_accept, w_load_err, w_load_cnt, w_dec, w_sample;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr_unpack
    assign w_addr_arr[gi] = bus.req_addr[gi*AW +: AW];
  end

  // First requester after the RR pointer, wrapping at NREQ
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_gnt_found && bus.req_vld[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_in_range = ({1'b0, r_addr} < c_cnt_lim);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_rdy   = '0;
    w_mux_sel   = '0;
    w_accept    = 1'b0;
    w_load_err  = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec       = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // No accept while in reset: the grant would be lost with the state
        if (w_gnt_found && !rst) begin
          w_req_rdy   = NREQ'(1) << w_gnt_idx;
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!w_in_range) begin
          w_load_err  = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_mux_sel = {{(CNT-1){1'b0}}, 1'b1} << r_addr;
          if (LATENCY == 0) begin
            w_sample    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_load_cnt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd1) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= PW'(NREQ - 1);
      r_gnt      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr  <= w_gnt_idx;
        r_gnt  <= w_gnt_idx;
        r_addr <= w_addr_arr[w_gnt_idx];
      end
      if (w_load_cnt) r_cnt <= c_lat;
      if (w_dec)      r_cnt <= r_cnt - 2'd1;
      if (w_load_err) begin
        r_rsp_id   <= IDW'(r_gnt);
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
      // Only this cycle looks at mux_dout_vld; stale hits elsewhere are ignored
      if (w_sample) begin
        r_rsp_id   <= IDW'(r_gnt);
        r_rsp_data <= bus.mux_dout_vld ? bus.mux_dout : '0;
        r_rsp_err  <= ~bus.mux_dout_vld;
      end
    end
  end

  assign bus.req_rdy  = w_req_rdy;
  assign bus.mux_sel  = w_mux_sel;
  assign bus.rsp_vld  = (r_state == S_RESP);
  assign bus.rsp_id   = r_rsp_id;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;
  assign bus.busy     = (r_state != S_IDLE);

`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr)
      r_err_cnt <= '0;
    else if (r_state == S_RESP && bus.rsp_rdy && r_rsp_err && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_split_mux_rd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_split_mux_rd_sched
// Desc    : Self-checking bench for split_mux_rd_sched with a fixed-latency
//           mux model and a round-robin/response reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_split_mux_rd_sched;
  localparam int WIDTH = 32, CNT = 31, AW = 5, NREQ = 2, IDW = 1, LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  split_mux_rd_sched_if #(.WIDTH(WIDTH), .CNT(CNT), .AW(AW), .NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
`endif

  split_mux_rd_sched #(.WIDTH(WIDTH), .CNT(CNT), .AW(AW), .NREQ(NREQ), .IDW(IDW),
                       .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr),
    .err_cnt(err_cnt),
`endif
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int m_ptr = NREQ - 1;
  logic [WIDTH-1:0] mem [CNT];
  bit               hit [CNT];

  // Split mux model: data for a select pulse appears LATENCY cycles later, for one cycle;
  // in every other cycle mux_dout_vld is random noise
  initial begin
    logic [CNT-1:0] sel_cap, s1, s2;
    int idx;
    sel_cap = '0; s1 = '0; s2 = '0;
    bus.mux_dout = '0;
    bus.mux_dout_vld = 1'b0;
    forever begin
      @(negedge clk);
      sel_cap = bus.mux_sel;
      @(posedge clk);
      #1;
      s2 = s1;
      s1 = sel_cap;
      if (s2 != '0) begin
        idx = 0;
        for (int i = 0; i < CNT; i++) if (s2[i]) idx = i;
        bus.mux_dout     = mem[idx];
        bus.mux_dout_vld = hit[idx];
      end else begin
        bus.mux_dout     = $urandom;
        bus.mux_dout_vld = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Stimulus only: runs one isolated transaction with rsp_rdy high and reports what it saw
  task automatic run_one(input int r, input int a, output int lat, output int nsel,
                         output logic [CNT-1:0] sel_or, output logic [IDW-1:0] id,
                         output logic [WIDTH-1:0] data, output logic err, output bit tmo);
    int n;
    tmo = 1'b0; lat = 0; nsel = 0; sel_or = '0; id = '0; data = '0; err = 1'b0;
    @(negedge clk);
    bus.rsp_rdy = 1'b1;
    bus.req_addr[r*AW +: AW] = AW'(a);
    bus.req_vld[r] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_rdy[r] && n < 30) begin @(negedge clk); #1; n++; end
    if (!bus.req_rdy[r]) begin tmo = 1'b1; bus.req_vld[r] = 1'b0; return; end
    m_ptr = r;
    n = 0;
    do begin
      @(negedge clk);
      bus.req_vld[r] = 1'b0;
      #1;
      n++;
      if (bus.mux_sel != '0) begin nsel++; sel_or |= bus.mux_sel; end
    end while (!bus.rsp_vld && n < 30);
    if (!bus.rsp_vld) begin tmo = 1'b1; return; end
    lat = n; id = bus.rsp_id; data = bus.rsp_data; err = bus.rsp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_vld = '0; bus.req_addr = '0; bus.rsp_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_rdy !== '0) begin failures++; $display("FAIL reset_req_rdy got=%b exp=0", bus.req_rdy); end
    checks++; if (bus.mux_sel !== '0) begin failures++; $display("FAIL reset_mux_sel got=%h exp=0", bus.mux_sel); end
    checks++; if (bus.rsp_vld !== 1'b0) begin failures++; $display("FAIL reset_rsp_vld got=%b exp=0", bus.rsp_vld); end
    checks++; if (bus.rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
  endtask

  task automatic test_single_read();
    int lat, nsel; logic [CNT-1:0] sel; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit tmo;
    logic [CNT-1:0] exp_sel;
    mem[5] = 32'hDEADBEEF; hit[5] = 1'b1;
    exp_sel = '0; exp_sel[5] = 1'b1;
    run_one(0, 5, lat, nsel, sel, id, d, e, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL single_timeout got=timeout exp=response"); return; end
    checks++; if (lat != LATENCY + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, LATENCY + 2); end
    checks++; if (nsel != 1 || sel !== exp_sel) begin failures++; $display("FAIL single_mux_sel got=%0d pulses sel=%h exp=1 pulse sel=%h", nsel, sel, exp_sel); end
    checks++; if (id !== 1'b0) begin failures++; $display("FAIL single_id got=%0d exp=0", id); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", e); end
  endtask

  task automatic test_out_of_range();
    int lat, nsel; logic [CNT-1:0] sel; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit tmo;
    run_one(0, 31, lat, nsel, sel, id, d, e, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL oor_timeout got=timeout exp=response"); return; end
    checks++; if (nsel != 0) begin failures++; $display("FAIL oor_mux_sel got=%0d pulses sel=%h exp=0 pulses", nsel, sel); end
    checks++; if (id !== 1'b0 || d !== '0 || e !== 1'b1) begin failures++; $display("FAIL oor_rsp got=id%0d data=%h err=%b exp=id0 data=0 err=1", id, d, e); end
  endtask

  task automatic test_decode_miss();
    int lat, nsel; logic [CNT-1:0] sel; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit tmo;
    hit[7] = 1'b0;
    run_one(1, 7, lat, nsel, sel, id, d, e, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL miss_timeout got=timeout exp=response"); return; end
    checks++; if (lat != LATENCY + 2) begin failures++; $display("FAIL miss_latency got=%0d exp=%0d", lat, LATENCY + 2); end
    checks++; if (id !== 1'b1 || d !== '0 || e !== 1'b1) begin failures++; $display("FAIL miss_rsp got=id%0d data=%h err=%b exp=id1 data=0 err=1", id, d, e); end
  endtask

  task automatic test_contention();
    int addr [NREQ];
    int exp_g, ngr, nrsp, n, last_acc;
    int q_id[$]; logic [WIDTH-1:0] q_data[$];
    logic [NREQ-1:0] exp_rdy;
    addr[0] = 3; addr[1] = 12; hit[3] = 1'b1; hit[12] = 1'b1;
    @(negedge clk);
    bus.rsp_rdy = 1'b1;
    for (int r = 0; r < NREQ; r++) bus.req_addr[r*AW +: AW] = AW'(addr[r]);
    bus.req_vld = '1;
    ngr = 0; nrsp = 0; n = 0; last_acc = -1;
    while ((ngr < 4 || nrsp < 4) && n < 80) begin
      #1;
      if (bus.req_rdy != '0) begin
        exp_g = (m_ptr + 1) % NREQ;
        exp_rdy = '0; exp_rdy[exp_g] = 1'b1;
        checks++; if (bus.req_rdy !== exp_rdy) begin failures++; $display("FAIL cont_grant got=%b exp=%b", bus.req_rdy, exp_rdy); end
        if (last_acc >= 0) begin
          checks++; if (n - last_acc != LATENCY + 3) begin failures++; $display("FAIL cont_throughput got=%0d exp=%0d", n - last_acc, LATENCY + 3); end
        end
        last_acc = n; m_ptr = exp_g; ngr++;
        q_id.push_back(exp_g); q_data.push_back(mem[addr[exp_g]]);
      end
      if (bus.rsp_vld) begin
        checks++;
        if (q_id.size() == 0) begin failures++; $display("FAIL cont_rsp got=unexpected response exp=none"); end
        else begin
          if (bus.rsp_id !== IDW'(q_id[0]) || bus.rsp_data !== q_data[0] || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL cont_rsp got=id%0d data=%h err=%b exp=id%0d data=%h err=0", bus.rsp_id, bus.rsp_data, bus.rsp_err, q_id[0], q_data[0]);
          end
          void'(q_id.pop_front()); void'(q_data.pop_front());
        end
        nrsp++;
      end
      @(negedge clk);
      n++;
      if (ngr >= 4) bus.req_vld = '0;
    end
    bus.req_vld = '0;
    checks++; if (ngr != 4 || nrsp != 4) begin failures++; $display("FAIL cont_timeout got=%0d grants %0d rsps exp=4 4", ngr, nrsp); end
  endtask

  task automatic test_backpressure_reset();
    int n, bad;
    logic [IDW-1:0] id0; logic [WIDTH-1:0] d0; logic e0;
    logic [CNT-1:0] exp_sel;
    mem[9] = $urandom; hit[9] = 1'b1; hit[20] = 1'b1;
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
    bus.req_addr[0 +: AW] = AW'(9);
    bus.req_vld[0] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_rdy[0] && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.req_vld[0] = 1'b0;
    bus.req_addr[AW +: AW] = AW'(20);
    bus.req_vld[1] = 1'b1;
    #1;
    n = 0;
    while (!bus.rsp_vld && n < 20) begin @(negedge clk); #1; n++; end
    id0 = bus.rsp_id; d0 = bus.rsp_data; e0 = bus.rsp_err;
    checks++;
    if (bus.rsp_vld !== 1'b1 || id0 !== 1'b0 || d0 !== mem[9] || e0 !== 1'b0) begin
      failures++; $display("FAIL bp_rsp got=vld%b id%0d data=%h err=%b exp=vld1 id0 data=%h err=0", bus.rsp_vld, id0, d0, e0, mem[9]);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_vld !== 1'b1 || bus.rsp_id !== id0 || bus.rsp_data !== d0 ||
          bus.rsp_err !== e0 || bus.req_rdy !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
    @(negedge clk);
    bus.rsp_rdy = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.req_rdy[1] && n < 20);
    checks++; if (bus.req_rdy !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", bus.req_rdy); end
    @(negedge clk);
    bus.req_vld[1] = 1'b0;
    #1;
    exp_sel = '0; exp_sel[20] = 1'b1;
    checks++; if (bus.mux_sel !== exp_sel) begin failures++; $display("FAIL bp_mux_sel got=%h exp=%h", bus.mux_sel, exp_sel); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = NREQ - 1;
    #1;
    checks++;
    if ({bus.req_rdy, bus.mux_sel, bus.rsp_vld, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.busy} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=rdy%b sel%h vld%b id%0d data%h err%b busy%b exp=all 0",
        bus.req_rdy, bus.mux_sel, bus.rsp_vld, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.busy);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_vld !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_stale got=%0d active cycles exp=0", bad); end
  endtask

  task automatic test_random();
    int q_id[$]; logic [WIDTH-1:0] q_data[$]; bit q_err[$];
    bit drop [NREQ];
    bit inflight;
    int g, a;
    logic [NREQ-1:0] exp_rdy;
    inflight = 1'b0;
    for (int r = 0; r < NREQ; r++) drop[r] = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        if (drop[r]) begin
          bus.req_vld[r] = 1'b0; drop[r] = 1'b0;
        end else if (!bus.req_vld[r]) begin
          if (c < 750 && $urandom_range(0, 2) == 0) begin
            a = ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, CNT - 1));
            bus.req_addr[r*AW +: AW] = AW'(a);
            bus.req_vld[r] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          bus.req_vld[r] = 1'b0;
        end
      end
      bus.rsp_rdy = (c >= 750) || ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && bus.req_vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      if (!inflight && g >= 0) exp_rdy[g] = 1'b1;
      checks++; if (bus.req_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, bus.req_rdy, exp_rdy); end
      if (!inflight && g >= 0) begin
        a = int'(bus.req_addr[g*AW +: AW]);
        q_id.push_back(g);
        if (a >= CNT)    begin q_data.push_back('0);     q_err.push_back(1'b1); end
        else if (hit[a]) begin q_data.push_back(mem[a]); q_err.push_back(1'b0); end
        else             begin q_data.push_back('0);     q_err.push_back(1'b1); end
        m_ptr = g; drop[g] = 1'b1; inflight = 1'b1;
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        checks++;
        if (q_id.size() == 0) begin failures++; $display("FAIL rnd_rsp cyc=%0d got=unexpected response exp=none", c); end
        else begin
          if (bus.rsp_id !== IDW'(q_id[0]) || bus.rsp_data !== q_data[0] || bus.rsp_err !== q_err[0]) begin
            failures++; $display("FAIL rnd_rsp cyc=%0d got=id%0d data=%h err=%b exp=id%0d data=%h err=%b",
              c, bus.rsp_id, bus.rsp_data, bus.rsp_err, q_id[0], q_data[0], q_err[0]);
          end
          void'(q_id.pop_front()); void'(q_data.pop_front()); void'(q_err.pop_front());
        end
        inflight = 1'b0;
      end
    end
    checks++; if (q_id.size() != 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0d pending busy=%b exp=0 pending busy=0", q_id.size(), bus.busy); end
    bus.req_vld = '0;
  endtask

`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
  task automatic test_err_cnt();
    int lat, nsel; logic [CNT-1:0] sel; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit tmo;
    @(negedge clk); err_cnt_clr = 1'b1;
    @(negedge clk); err_cnt_clr = 1'b0;
    #1;
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL errcnt_clear got=%0d exp=0", err_cnt); end
    for (int i = 0; i < 3; i++) run_one(0, 31, lat, nsel, sel, id, d, e, tmo);
    #1;
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL errcnt_three got=%0d exp=3", err_cnt); end
    err_cnt_clr = 1'b1;
    run_one(0, 31, lat, nsel, sel, id, d, e, tmo);
    #1;
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL errcnt_clr_wins got=%0d exp=0", err_cnt); end
    err_cnt_clr = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < CNT; i++) begin
      mem[i] = $urandom;
      hit[i] = ($urandom_range(0, 3) != 0);
    end
    test_reset();
    test_single_read();
    test_out_of_range();
    test_decode_miss();
    test_contention();
    test_backpressure_reset();
    test_random();
`ifdef SPLIT_MUX_RD_SCHED_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
